// File: rtl/spi_pkg.sv
// Shared widths and the controller state type for the SPI register-access block.
package spi_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: pulses tick every CLK_DIV cycles while enabled,
// restarting from zero whenever the enable drops.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count cycles within a half period, wrapping at CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing 16-bit {wr, addr, wdata} frames MSB first and
// capturing the peripheral's reply byte into rdata.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              miso,
  output logic              sclk,
  output logic              ncs,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  spi_state_e         state_q, state_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic               sclk_d, ncs_d, mosi_d, busy_d, done_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               tick_en, tick;

  assign tick_en = (state_q != ST_IDLE);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  // State, shift registers and all pin outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk    <= sclk_d;
      ncs     <= ncs_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
      rdata   <= rdata_d;
    end
  end

  // Next-state and next-output logic; phases advance only on half-period ticks.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk;
    ncs_d   = ncs;
    mosi_d  = mosi;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          tx_d    = {wr, addr, wdata};
          rx_d    = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = wr;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[FRAME_W-2:0], miso};
          end else begin
            // mosi moves to the next bit on the falling edge so it is stable
            // for the whole following high phase.
            sclk_d = 1'b0;
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
            mosi_d = tx_q[FRAME_W-2];
            if (bit_q == 4'd15) begin
              state_d = ST_HOLD;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = rx_q[DATA_W-1:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks each done.
module tb_spi_controller;

  localparam int unsigned D = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       wr;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       miso;
  logic       sclk;
  logic       ncs;
  logic       mosi;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    bit          chk_gap;
  } exp_t;

  exp_t        sb[$];
  int          tests;
  int          fails;
  int          rise_cnt;
  int          done_cnt;
  logic [7:0]  regs [0:127];

  spi_controller #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .miso  (miso),
    .sclk  (sclk),
    .ncs   (ncs),
    .mosi  (mosi),
    .busy  (busy),
    .done  (done),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: captures mosi on sclk rises, measures ncs runs, checks on done.
  initial begin : monitor
    logic        sclk_p;
    logic        ncs_p;
    logic [15:0] cap;
    int          low_run;
    int          high_run;
    int          last_low;
    int          last_gap;
    exp_t        e;
    sclk_p = 1'b0; ncs_p = 1'b1; cap = '0;
    low_run = 0; high_run = 0; last_low = 0; last_gap = 0;
    rise_cnt = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      if (!ncs) begin
        if (ncs_p) begin
          last_gap = high_run;
          high_run = 0;
          cap      = '0;
          rise_cnt = 0;
        end
        low_run++;
      end else begin
        if (!ncs_p) begin
          last_low = low_run;
          low_run  = 0;
        end
        high_run++;
      end
      if (sclk && !sclk_p) begin
        cap = {cap[14:0], mosi};
        rise_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected no pending frame");
        end else begin
          e = sb.pop_front();
          check("frame", 32'(cap), 32'(e.frame));
          check("ncs_low_cycles", last_low, 34 * D);
          check("rdata", 32'(rdata), 32'(e.rdata));
          check("busy_at_done", 32'(busy), 32'd0);
          if (e.chk_gap) check("ncs_gap_cycles", last_gap, D + 1);
        end
      end
      sclk_p = sclk;
      ncs_p  = ncs;
    end
  end

  // Peripheral model: replies {8'h00, regs[addr]}, commits writes at frame end.
  initial begin : periph
    logic        sclk_p;
    logic        ncs_p;
    int          k;
    logic [15:0] rx;
    logic [7:0]  resp;
    sclk_p = 1'b0; ncs_p = 1'b1; k = 0; rx = '0; resp = '0; miso = 1'b0;
    forever begin
      @(negedge clk);
      if (ncs && !ncs_p && k == 16 && rx[15]) regs[rx[14:8]] = rx[7:0];
      if (!ncs && ncs_p) begin
        k = 0; rx = '0; miso = 1'b0;
      end
      if (!ncs && sclk && !sclk_p) begin
        rx = {rx[14:0], mosi};
        k++;
        if (k == 8) resp = regs[rx[6:0]];
        miso = (k >= 8 && k < 16) ? resp[15 - k] : 1'b0;
      end
      sclk_p = sclk;
      ncs_p  = ncs;
    end
  end

  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] er, input bit gap);
    exp_t e;
    e.frame = {w, a, d};
    e.rdata = er;
    e.chk_gap = gap;
    sb.push_back(e);
    wr = w; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL timeout_%s: done=0 after 200 cycles, expected done=1", name);
    end
  endtask

  task automatic wait_rise(input int target);
    int n;
    n = 0;
    while (n < 200 && rise_cnt != target) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rise_cnt != target) begin
      fails++;
      $display("FAIL timeout_rise: got %0d rises, expected %0d", rise_cnt, target);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    for (int unsigned i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h10] = 8'hA5;
    idle(3);
    check("rst_ncs", 32'(ncs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    idle(2);

    issue(1'b1, 7'h00, 8'hFF, 8'h00, 1'b0); wait_done("f80ff"); idle(3);
    issue(1'b1, 7'h04, 8'h80, 8'h00, 1'b0); wait_done("f8480"); idle(3);
    issue(1'b0, 7'h04, 8'h00, 8'h80, 1'b0); wait_done("f0400"); idle(3);

    // Start while busy must not disturb the frame in flight.
    issue(1'b1, 7'h22, 8'h3C, 8'h00, 1'b0);
    wait_rise(5);
    wr = 1'b0; addr = 7'h7F; wdata = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("fa23c"); idle(3);

    issue(1'b0, 7'h10, 8'h00, 8'hA5, 1'b0); wait_done("f1000"); idle(3);

    // Reset in mid-shift aborts the frame with no done.
    wr = 1'b1; addr = 7'h33; wdata = 8'h99; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_rise(9);
    rst = 1'b1;
    #1;
    check("abort_ncs", 32'(ncs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    issue(1'b1, 7'h01, 8'h55, 8'h00, 1'b0); wait_done("f8155"); idle(3);

    // Back-to-back: start raised in the done cycle.
    issue(1'b0, 7'h01, 8'h00, 8'h55, 1'b0); wait_done("f0100");
    issue(1'b0, 7'h00, 8'h00, 8'hFF, 1'b1); wait_done("f0000");

    idle(10);
    check("pending_frames", sb.size(), 32'd0);
    check("done_count", done_cnt, 32'd8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
